// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional build macro PS2_HOST_TX_RETRY_EN adds up to two automatic retries on NACK/timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  output logic [2:0] state_dbg
);
  // Handshake: tx_data is taken on a clock edge where tx_valid & tx_ready are both high;
  // tx_ready is high only in IDLE and tx_valid is not looked at anywhere else.

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  clk_s;
  logic [1:0]  data_s;
  logic [7:0]  byte_q;
  logic [9:0]  frame;
  logic [3:0]  bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic        idle_seen;
  logic        fall, idle_ok, inh_done, to_hit;
  logic        accept, fail_ack, fail_to;
  logic        clk_oe_n, data_oe_n, done_n, ack_err_n, timeout_n;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]  retry_cnt;
  logic        retry;
`endif

  assign fall      = clk_s[2] & ~clk_s[1];
  assign idle_ok   = clk_s[1] & data_s[1];
  assign inh_done  = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
  assign to_hit    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    clk_oe_n  = 1'b0;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    timeout_n = 1'b0;
    accept    = 1'b0;
    fail_ack  = 1'b0;
    fail_to   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry     = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (tx_valid) begin
          accept   = 1'b1;
          state_n  = S_INHIBIT;
          clk_oe_n = 1'b1;
        end
      end
      S_INHIBIT: begin
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        if (inh_done) begin
          // Release clock and pull data low (start bit) on the same edge.
          state_n   = S_RTS;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
        end
      end
      S_RTS: begin
        data_oe_n = 1'b1;
        state_n   = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          data_oe_n = ~frame[0];
          if (bit_cnt == 4'd9) state_n = S_ACK;
        end else if (to_hit) begin
          fail_to = 1'b1;
        end
      end
      S_ACK: begin
        // A device clock edge beats a coincident timeout.
        if (fall) begin
          if (data_s[1]) begin
            fail_ack = 1'b1;
          end else begin
            done_n  = 1'b1;
            state_n = S_WAIT_IDLE;
          end
        end else if (to_hit) begin
          fail_to = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        data_oe_n = 1'b0;
        if (idle_ok && idle_seen) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (fail_ack || fail_to) begin
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry     = 1'b1;
        state_n   = S_INHIBIT;
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
      end else
`endif
      begin
        ack_err_n = fail_ack;
        timeout_n = fail_to;
        state_n   = fail_ack ? S_WAIT_IDLE : S_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= (state_n != S_IDLE);
      tx_ready    <= (state_n == S_IDLE);
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout     <= timeout_n;
    end
  end

  // Datapath; the frame is rebuilt from the latched byte at every inhibit so retries resend it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s     <= 3'b111;
      data_s    <= 2'b11;
      byte_q    <= 8'h00;
      frame     <= 10'h3ff;
      bit_cnt   <= 4'd0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      idle_seen <= 1'b0;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk};
      data_s <= {data_s[0], ps2_data};
      if (accept) byte_q <= tx_data;
      if (state == S_INHIBIT) begin
        frame   <= {1'b1, ~^byte_q, byte_q};
        bit_cnt <= 4'd0;
      end else if (state == S_SEND && fall) begin
        frame   <= {1'b0, frame[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
      if (state == S_INHIBIT) to_cnt <= '0;
      else if (state inside {S_RTS, S_SEND, S_ACK}) to_cnt <= to_cnt + 1'b1;
      idle_seen <= (state == S_WAIT_IDLE) && idle_ok;
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retry_cnt <= 2'd0;
    else if (accept) retry_cnt <= 2'd0;
    else if (retry)  retry_cnt <= retry_cnt + 2'd1;
  end
`endif

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send-side counterpart of the keyboard receiver.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the host request-to-send sequence over the shared open-drain ps2_clk/ps2_data lines.
- Sits beside the receiver on the same pins; the receiver ignores traffic while busy=1.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to ACK edge (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk  in  1  raw line level
- ps2_data  in  1  raw line level
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: device ACKed
- ack_err  out  1  one-cycle pulse: ACK bit sampled high
- timeout  out  1  one-cycle pulse: TIMEOUT_CYCLES exceeded

Behaviour:
- Reset (async): state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_ready=1, done/ack_err/timeout=0. Lines are released the instant reset asserts, including mid-frame.
- Synchroniser: ps2_clk passes through a 3-stage sync. fall = s[2] & ~s[1]. ps2_data is sampled through 2 stages.
- Accept: in IDLE with tx_valid=1, latch tx_data, compute parity = ~^tx_data (odd), set bit counter=0, go to INHIBIT next cycle. tx_valid is ignored outside IDLE.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: data_oe=1 (start bit 0) and clk_oe=0 in the same cycle. Clear the timeout counter, go to SEND.
- SEND: on each fall, drive the next bit; data_oe = ~bit.
  - falls 1..8: data bits 0..7, LSB first.
  - fall 9: parity.
  - fall 10: stop bit (data_oe=0), go to ACK.
- ACK: on the next fall, sample synced ps2_data.
  - 0: pulse done.
  - 1: pulse ack_err.
  - Either way, go to WAIT_IDLE.
- WAIT_IDLE: wait until synced ps2_clk=1 and ps2_data=1 for 2 consecutive cycles, then IDLE.
- Timeout: counter runs in SEND/ACK. On reaching TIMEOUT_CYCLES, release both lines, pulse timeout, go to IDLE (not WAIT_IDLE). If timeout and an ACK fall land in the same cycle, the ACK wins.
- Pulses fire in the transition cycle. Exactly one of done/ack_err/timeout fires per accepted byte.
- Outputs are registered. tx_ready = (state==IDLE) and falls in the cycle after acceptance.
- Clock and data are never both driven except during the RTS→SEND handoff instant; clk_oe is 0 in every state except INHIBIT.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On ack_err or timeout, re-run INHIBIT→RTS with the latched byte, up to 2 retries (3 attempts total).
  - done pulses on any successful attempt; ack_err/timeout pulses only after the final failed attempt.
  - busy stays high across retries, and tx_ready stays low.
- Undefined: no retry; the first failure is reported immediately. No retry counter is present.

Test Plan:
- Reset mid-INHIBIT (clk_oe=1) -> clk_oe=0 and data_oe=0 within the same cycle; state=IDLE; tx_ready=1.
- tx_data=0xED with a device model clocking at 12.5 kHz -> clk_oe high exactly INHIBIT_CYCLES. Model samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs 0 -> one done pulse; busy falls after lines idle.
- tx_data=0x01 -> model samples parity 0. tx_data=0xFF -> parity 1. Both end in done.
- Model leaves data high at ACK -> ack_err pulse, no done. With RETRY_EN and a model NACKing twice then ACKing -> 3 INHIBIT phases, a single done, no ack_err.
- Model never clocks after RTS -> timeout pulse exactly TIMEOUT_CYCLES after RTS; both oe=0; tx_ready=1. With RETRY_EN -> 3 attempts, then timeout.
- tx_valid held high across done -> second byte accepted only after WAIT_IDLE returns to IDLE. tx_valid during SEND is ignored and the latched byte is unchanged.
